button_event: RTL

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 117 +++++++++++
 1 files changed

// File: rtl/button_event.sv
// button_event: classifies a debounced, active-low pushbutton into
// press, release, short, long and auto-repeat one-cycle strobes,
// plus a "held" level. All outputs come straight from flops.
module button_event #(
    parameter logic [25:0] LONG_CYCLES   = 26'd25_000_000,
    parameter logic [25:0] REPEAT_CYCLES = 26'd5_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic PB_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [1:0] WAIT_REL = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] PRESS    = 2'd2;
    localparam logic [1:0] REPEAT   = 2'd3;

    // Terminal counts. PRESS stops one short of LONG_CYCLES because the
    // sample taken on entry from IDLE already counts as the first pressed one.
    localparam logic [25:0] LONG_LAST   = LONG_CYCLES - 26'd2;
    localparam logic [25:0] REPEAT_LAST = REPEAT_CYCLES - 26'd1;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [25:0] cnt;
    logic [25:0] cnt_next;
    logic        press_next;
    logic        release_next;
    logic        short_next;
    logic        long_next;
    logic        repeat_next;

    // Next-state and event decode; a release always takes priority over a
    // long or repeat that would otherwise fire on the same edge.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            WAIT_REL: begin
                if (PB_db) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!PB_db) begin
                    state_next = PRESS;
                    cnt_next   = 26'd0;
                    press_next = 1'b1;
                end
            end
            PRESS: begin
                if (PB_db) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    short_next   = 1'b1;
                end else if (cnt == LONG_LAST) begin
                    state_next = REPEAT;
                    cnt_next   = 26'd0;
                    long_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 26'd1;
                end
            end
            REPEAT: begin
                if (PB_db) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    cnt_next    = 26'd0;
                    repeat_next = 1'b1;
                end else begin
                    cnt_next = cnt + 26'd1;
                end
            end
            default: begin
                state_next = WAIT_REL;
                cnt_next   = 26'd0;
            end
        endcase
    end

    // State, counter and output registers; reset parks in WAIT_REL so a
    // button already down at reset release is ignored until it is let go.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= WAIT_REL;
            cnt           <= 26'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            short_pulse   <= short_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= (state_next == PRESS) || (state_next == REPEAT);
        end
    end

endmodule
